// File: rtl/layer_seq_pkg.sv
// Shared types and width helpers for the layer sequencer.
package layer_seq_pkg;

    typedef enum logic [1:0] {
        FEED  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Counter width that can hold 0..n
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Index width for 0..n-1, never narrower than one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_seq_buf.sv
// Per-neuron result capture registers with captured mask and completion detect.
module layer_seq_buf
    import layer_seq_pkg::*;
#(
    parameter int NUM_NEURON = 30,
    parameter int DATA_WIDTH = 16,
    parameter int IW         = cnt_w(NUM_NEURON)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cap_en,
    input  logic                             clr,
    input  logic [NUM_NEURON*DATA_WIDTH-1:0] n_out,
    input  logic [NUM_NEURON-1:0]            n_outvalid,
    input  logic [IW-1:0]                    rd_idx,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             dup,
    output logic                             all_next
);

    logic [NUM_NEURON-1:0][DATA_WIDTH-1:0] mem;
    logic [NUM_NEURON-1:0]                 mask;
    logic [NUM_NEURON-1:0]                 hit;

    assign hit      = cap_en ? n_outvalid : '0;
    assign dup      = |(hit & mask);
    assign all_next = &(mask | hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mask <= '0;
        else if (clr)
            mask <= '0;
        else
            mask <= mask | hit;
    end

    // Contents are don't-care after reset, so no reset on the data array
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_NEURON; k++)
            if (hit[k])
                mem[k] <= n_out[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // Forward a same-cycle capture so the first drain element can load on the WAIT exit edge
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_NEURON; k++)
            if (rd_idx == IW'(k))
                rd_data = hit[k] ? n_out[k*DATA_WIDTH +: DATA_WIDTH] : mem[k];
    end

endmodule

// File: rtl/layer_seq.sv
// Fully-connected layer sequencer: broadcast input vector, collect neuron results, serialize them.
// Optional running argmax over drained results under LAYER_SEQ_ARGMAX_EN.
module layer_seq
    import layer_seq_pkg::*;
#(
    parameter int NUM_NEURON = 30,
    parameter int NUM_INPUT  = 784,
    parameter int DATA_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_WIDTH-1:0]            n_input,
    output logic                             n_input_valid,
    input  logic [NUM_NEURON*DATA_WIDTH-1:0] n_out,
    input  logic [NUM_NEURON-1:0]            n_outvalid,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             busy,
`ifdef LAYER_SEQ_ARGMAX_EN
    output logic [idx_w(NUM_NEURON)-1:0]     argmax_idx,
    output logic                             argmax_valid,
`endif
    output logic                             err
);

    localparam int CW = cnt_w(NUM_INPUT);
    localparam int OW = cnt_w(NUM_NEURON);

    state_t          state, state_nx;
    logic [CW-1:0]   in_cnt;
    logic [OW-1:0]   out_idx, rd_idx;
    logic [DATA_WIDTH-1:0] rd_data;
    logic            accept, last_in, xfer, last_out, dup, all_next, to_drain;

    assign accept   = in_valid & in_ready;
    assign last_in  = accept && (in_cnt == CW'(NUM_INPUT - 1));
    assign xfer     = out_valid & out_ready;
    assign last_out = xfer && (out_idx == OW'(NUM_NEURON - 1));
    assign to_drain = (state == WAIT) && all_next;
    // Prefetch the element after the one being transferred; index 0 when entering DRAIN
    assign rd_idx   = (state == DRAIN) ? out_idx + OW'(1) : '0;

    layer_seq_buf #(
        .NUM_NEURON (NUM_NEURON),
        .DATA_WIDTH (DATA_WIDTH),
        .IW         (OW)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .cap_en     (state == WAIT),
        .clr        (last_out),
        .n_out      (n_out),
        .n_outvalid (n_outvalid),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .dup        (dup),
        .all_next   (all_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= FEED;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state)
            FEED: begin
                in_ready = 1'b1;
                if (last_in) state_nx = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (all_next) state_nx = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (last_out) state_nx = FEED;
            end
            default: state_nx = FEED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_cnt        <= '0;
            out_idx       <= '0;
            n_input       <= '0;
            n_input_valid <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            err           <= 1'b0;
        end else begin
            n_input_valid <= accept;
            if (accept) begin
                n_input <= in_data;
                in_cnt  <= last_in ? '0 : in_cnt + CW'(1);
            end
            if (to_drain) begin
                out_valid <= 1'b1;
                out_idx   <= '0;
                out_data  <= rd_data;
            end
            if (xfer) begin
                if (last_out) begin
                    out_valid <= 1'b0;
                    out_idx   <= '0;
                end else begin
                    out_idx  <= out_idx + OW'(1);
                    out_data <= rd_data;
                end
            end
            if (((state != WAIT) && (|n_outvalid)) || dup)
                err <= 1'b1;
        end
    end

`ifdef LAYER_SEQ_ARGMAX_EN
    localparam int AW = idx_w(NUM_NEURON);

    logic [DATA_WIDTH-1:0] max_val;
    logic [AW-1:0]         max_idx;
    logic                  take;

    // Strict greater-than keeps the lower index on ties
    assign take = (out_idx == '0) || ($signed(out_data) > $signed(max_val));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_val      <= '0;
            max_idx      <= '0;
            argmax_idx   <= '0;
            argmax_valid <= 1'b0;
        end else begin
            argmax_valid <= 1'b0;
            if (xfer) begin
                if (take) begin
                    max_val <= out_data;
                    max_idx <= AW'(out_idx);
                end
                if (last_out) begin
                    argmax_valid <= 1'b1;
                    argmax_idx   <= take ? AW'(out_idx) : max_idx;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_layer_seq.sv
// Directed self-checking bench for layer_seq (4 neurons, 8 inputs, 16-bit data).
module tb_layer_seq;

    localparam int NN = 4;
    localparam int NI = 8;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   in_data;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   n_input;
    logic            n_input_valid;
    logic [NN*DW-1:0] n_out;
    logic [NN-1:0]   n_outvalid;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic            busy;
    logic            err;
`ifdef LAYER_SEQ_ARGMAX_EN
    logic [1:0]      argmax_idx;
    logic            argmax_valid;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    layer_seq #(.NUM_NEURON(NN), .NUM_INPUT(NI), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .n_input       (n_input),
        .n_input_valid (n_input_valid),
        .n_out         (n_out),
        .n_outvalid    (n_outvalid),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
`ifdef LAYER_SEQ_ARGMAX_EN
        .argmax_idx    (argmax_idx),
        .argmax_valid  (argmax_valid),
`endif
        .err           (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus-only helpers
    task automatic feed_quiet(input logic [DW-1:0] base);
        for (int i = 0; i < NI; i++) begin
            in_valid = 1'b1;
            in_data  = base + DW'(i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain_quiet();
        out_ready = 1'b1;
        for (int i = 0; i < NN; i++) tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_data = '0; in_valid = 1'b0; n_out = '0; n_outvalid = '0; out_ready = 1'b0;
        tick(); tick();
        n_checks++; if (n_input_valid !== 1'b0 || n_input !== '0) begin n_fail++; $display("FAIL reset_ninput: got v=%b d=%h want v=0 d=0000", n_input_valid, n_input); end
        n_checks++; if (out_valid !== 1'b0 || out_data !== '0) begin n_fail++; $display("FAIL reset_out: got v=%b d=%h want v=0 d=0000", out_valid, out_data); end
        n_checks++; if (busy !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got busy=%b err=%b want 0 0", busy, err); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef LAYER_SEQ_ARGMAX_EN
        n_checks++; if (argmax_valid !== 1'b0 || argmax_idx !== 2'd0) begin n_fail++; $display("FAIL reset_argmax: got v=%b i=%0d want 0 0", argmax_valid, argmax_idx); end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_continuous_feed();
        for (int i = 1; i <= NI; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            tick();
            n_checks++; if (n_input_valid !== 1'b1 || n_input !== DW'(i)) begin n_fail++; $display("FAIL feed_beat%0d: got v=%b d=%h want v=1 d=%h", i, n_input_valid, n_input, DW'(i)); end
            n_checks++; if (in_ready !== (i < NI)) begin n_fail++; $display("FAIL feed_ready%0d: got %b want %b", i, in_ready, (i < NI)); end
        end
        in_valid = 1'b0;
        tick();
        n_checks++; if (n_input_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL feed_wait: got v=%b busy=%b want v=0 busy=1", n_input_valid, busy); end
    endtask

    task automatic test_capture_drain();
        logic [DW-1:0] exp [NN];
        exp[0] = 16'h0001; exp[1] = 16'h0005; exp[2] = 16'h0007; exp[3] = 16'h0003;
        n_out = {16'h0000, 16'h0000, 16'h0005, 16'h0000};
        n_outvalid = 4'b0010;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL cap_partial: got out_valid=%b want 0", out_valid); end
        n_out = {16'h0003, 16'h0007, 16'hDEAD, 16'h0001};
        n_outvalid = 4'b1101;
        tick();
        n_outvalid = '0;
        n_out = '0;
        out_ready = 1'b1;
        for (int j = 0; j < NN; j++) begin
            n_checks++; if (out_valid !== 1'b1 || out_data !== exp[j]) begin n_fail++; $display("FAIL drain_elem%0d: got v=%b d=%h want v=1 d=%h", j, out_valid, out_data, exp[j]); end
            tick();
        end
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL drain_done: got ov=%b ir=%b busy=%b want 0 1 0", out_valid, in_ready, busy); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL drain_err: got %b want 0", err); end
`ifdef LAYER_SEQ_ARGMAX_EN
        n_checks++; if (argmax_valid !== 1'b1 || argmax_idx !== 2'd2) begin n_fail++; $display("FAIL argmax_a: got v=%b i=%0d want 1 2", argmax_valid, argmax_idx); end
        tick();
        n_checks++; if (argmax_valid !== 1'b0 || argmax_idx !== 2'd2) begin n_fail++; $display("FAIL argmax_a_hold: got v=%b i=%0d want 0 2", argmax_valid, argmax_idx); end
`endif
        out_ready = 1'b0;
    endtask

    task automatic test_gapped_feed();
        int pulses = 0;
        logic [DW-1:0] nxt = 16'h0010;
        for (int c = 0; c < 2*NI; c++) begin
            in_valid = (c % 2 == 0);
            in_data  = (c % 2 == 0) ? nxt + 16'h0001 : 16'hBEEF;
            tick();
            if (c % 2 == 0) nxt = nxt + 16'h0001;
            if (n_input_valid === 1'b1) pulses++;
            n_checks++; if (n_input_valid !== (c % 2 == 0) || ((c % 2 == 0) && n_input !== nxt)) begin n_fail++; $display("FAIL gap_c%0d: got v=%b d=%h want v=%b d=%h", c, n_input_valid, n_input, (c % 2 == 0), nxt); end
        end
        in_valid = 1'b0;
        n_checks++; if (pulses != NI || in_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL gap_total: got pulses=%0d ir=%b busy=%b want 8 0 1", pulses, in_ready, busy); end
    endtask

    task automatic test_stall_drain();
        logic [DW-1:0] exp [NN];
        logic [6:0] rdy = 7'b1110001;  // bit c used at cycle c: go, stall x3, go x3
        int j = 0;
        exp[0] = 16'h0009; exp[1] = 16'h8000; exp[2] = 16'h0009; exp[3] = 16'h0004;
        n_out = {16'h0004, 16'h0009, 16'h8000, 16'h0009};
        n_outvalid = 4'b1111;
        tick();
        n_outvalid = '0;
        n_checks++; if (out_valid !== 1'b1 || out_data !== exp[0]) begin n_fail++; $display("FAIL stall_first: got v=%b d=%h want v=1 d=%h", out_valid, out_data, exp[0]); end
        for (int c = 0; c < 7; c++) begin
            out_ready = rdy[c];
            tick();
            if (rdy[c]) j++;
            if (j < NN) begin
                n_checks++; if (out_valid !== 1'b1 || out_data !== exp[j]) begin n_fail++; $display("FAIL stall_c%0d: got v=%b d=%h want v=1 d=%h", c, out_valid, out_data, exp[j]); end
            end else begin
                n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_end: got ov=%b ir=%b want 0 1", out_valid, in_ready); end
`ifdef LAYER_SEQ_ARGMAX_EN
                n_checks++; if (argmax_valid !== 1'b1 || argmax_idx !== 2'd0) begin n_fail++; $display("FAIL argmax_tie: got v=%b i=%0d want 1 0", argmax_valid, argmax_idx); end
`endif
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_err();
        feed_quiet(16'h0100);
        n_out = {16'h0000, 16'h0022, 16'h0000, 16'h0000};
        n_outvalid = 4'b0100;
        tick();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_first_cap: got %b want 0", err); end
        n_out = {16'h0000, 16'h0033, 16'h0000, 16'h0000};
        tick();
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_dup: got %b want 1", err); end
        n_out = {16'h0044, 16'h0000, 16'h0042, 16'h0041};
        n_outvalid = 4'b1011;
        tick();
        n_outvalid = '0;
        out_ready = 1'b1;
        tick(); tick();
        n_checks++; if (out_data !== 16'h0033) begin n_fail++; $display("FAIL err_last_wins: got %h want 0033", out_data); end
        tick(); tick();
        out_ready = 1'b0;
        n_checks++; if (err !== 1'b1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got err=%b ir=%b want 1 1", err, in_ready); end
        rst = 1'b1; tick(); rst = 1'b0; tick();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", err); end
        n_outvalid = 4'b0001;
        tick();
        n_outvalid = '0;
        tick(); tick();
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_feed: got %b want 1", err); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h0200 + DW'(i);
            tick();
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (n_input_valid !== 1'b0 || n_input !== '0 || err !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_async: got v=%b d=%h err=%b busy=%b ir=%b want 0 0000 0 0 1", n_input_valid, n_input, err, busy, in_ready); end
        tick();
        rst = 1'b0;
        tick();
        for (int i = 1; i <= NI; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h0300 + DW'(i);
            tick();
            n_checks++; if (n_input_valid !== 1'b1 || n_input !== 16'h0300 + DW'(i) || in_ready !== (i < NI)) begin n_fail++; $display("FAIL mid_beat%0d: got v=%b d=%h ir=%b want 1 %h %b", i, n_input_valid, n_input, in_ready, 16'h0300 + DW'(i), (i < NI)); end
        end
        in_valid = 1'b0;
        n_out = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
        n_outvalid = 4'b1111;
        tick();
        n_outvalid = '0;
        n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h000A) begin n_fail++; $display("FAIL mid_drain0: got v=%b d=%h want 1 000a", out_valid, out_data); end
        drain_quiet();
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL mid_done: got ov=%b ir=%b err=%b want 0 1 0", out_valid, in_ready, err); end
    endtask

    initial begin
        test_reset();
        test_continuous_feed();
        test_capture_drain();
        test_gapped_feed();
        test_stall_drain();
        test_err();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_seq.md
Name: layer_seq

Overview:
- Sequencer for one fully-connected layer of neuron instances.
- Accepts the layer's input vector from an upstream valid/ready stream and broadcasts it, one element per cycle, to all neurons of the layer.
- Collects every neuron's result as its outvalid pulses, then serializes the results in neuron order to the next layer over a valid/ready stream.
- Sits between consecutive layers in the network top; replaces ad-hoc per-layer glue.

Parameters:
- NUM_NEURON, 30, neurons in the layer; also the number of output elements.
- NUM_INPUT, 784, input elements per vector; equals each neuron's numWeight.
- DATA_WIDTH, 16, element width, same as the neuron dataWidth.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  DATA_WIDTH  upstream element.
- in_valid  in  1  upstream element valid.
- in_ready  out  1  block accepts an element when in_valid&in_ready.
- n_input  out  DATA_WIDTH  broadcast element, drives every neuron myinput.
- n_input_valid  out  1  broadcast valid, drives every neuron myinputValid.
- n_out  in  NUM_NEURON*DATA_WIDTH  neuron outputs; neuron k occupies bits [k*DATA_WIDTH+:DATA_WIDTH].
- n_outvalid  in  NUM_NEURON  per-neuron outvalid pulses.
- out_data  out  DATA_WIDTH  serialized result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- busy  out  1  high in WAIT or DRAIN.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (async): state=FEED; in_cnt=0; out_idx=0; captured mask=0; n_input=0; n_input_valid=0; out_valid=0; out_data=0; err=0; busy=0. Buffer contents are don't-care.
- FEED: in_ready=1.
  - On an accepted beat, register n_input<=in_data and n_input_valid<=1 (1-cycle latency); in_cnt++.
  - No accepted beat in a cycle gives n_input_valid=0 next cycle. Gaps are legal.
  - When beat NUM_INPUT-1 is accepted, go to WAIT and clear in_cnt. in_ready drops the same edge.
- WAIT: in_ready=0; n_input_valid=0 from the cycle after the last beat.
  - For each k with n_outvalid[k]=1: buf[k]<=n_out slice k; captured[k]<=1.
  - Multiple neurons may pulse in the same cycle; all are captured.
  - When the mask is all ones (including bits set that edge), go to DRAIN with out_idx=0.
- DRAIN: out_valid=1; out_data=buf[out_idx], registered.
  - On out_valid&out_ready: out_idx++.
  - After index NUM_NEURON-1 transfers: clear the mask, out_valid=0, return to FEED.
  - out_data holds stable while out_ready=0.
- Next vector: in_ready stays 0 during WAIT and DRAIN. There is no overlap between vectors.
- err (set, sticky until rst):
  - n_outvalid[k] in FEED or DRAIN.
  - n_outvalid[k] in WAIT while captured[k] is already 1.
  - A capture is still performed on a duplicate in WAIT (last wins).
- Counter widths: in_cnt is $clog2(NUM_INPUT+1) bits; out_idx is $clog2(NUM_NEURON+1) bits. Counters do not wrap; they are cleared explicitly on state exit.
- Reset mid-operation: immediate return to reset values. A partially fed vector is discarded; neurons are reset by the same rst.

Optional Feature:
- Macro LAYER_SEQ_ARGMAX_EN.
- Defined:
  - Extra ports argmax_idx out $clog2(NUM_NEURON) and argmax_valid out 1.
  - During DRAIN, a running signed max tracks each transferred element; ties keep the lower index.
  - argmax_valid pulses 1 cycle on the edge after the last transfer, with argmax_idx valid that cycle and held until the next pulse.
  - Reset: argmax_idx=0, argmax_valid=0.
- Undefined: ports absent, no comparator logic; behaviour otherwise identical.

Decomposition:
- Package layer_seq_pkg: state enum (FEED, WAIT, DRAIN), width functions/constants for the counters.
- Sub-module layer_seq_buf: NUM_NEURON×DATA_WIDTH capture registers plus the captured mask and all-captured flag. The FSM and stream logic stay in layer_seq.

Test Plan (NUM_NEURON=4, NUM_INPUT=8, DATA_WIDTH=16):
- Continuous feed of 8 beats 1..8 → n_input_valid high 8 consecutive cycles with values 1..8, each 1 cycle after acceptance; in_ready low from the edge after beat 8.
- Feed with in_valid low every other cycle → n_input_valid mirrors the gaps; exactly 8 valid pulses; enters WAIT.
- n_outvalid pulses 4'b0010 (n_out[1]=0x0005), then 4'b1101 (0x0001, -, 0x0007, 0x0003) → DRAIN; outputs 0x0001, 0x0005, 0x0007, 0x0003 in order; then in_ready=1.
- out_ready low 3 cycles mid-drain → out_data held; no skipped or repeated element.
- Duplicate n_outvalid[2] in WAIT, or n_outvalid[0] during FEED → err=1, stays 1 until rst.
- rst asserted after beat 5 → all outputs 0 asynchronously; a fresh 8-beat vector then completes normally. With LAYER_SEQ_ARGMAX_EN, the drain above gives argmax_idx=2 with a one-cycle argmax_valid pulse.
